mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15, is the maximum BUSY cycles without mem_ready before forced release; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 req  input  4  per-requester access request; bit i = requester i.
REQ-005 wdata0..wdata3  input  32 each  per-requester write data.
REQ-006 mem_ready  input  1  shared memory port completes current transaction this cycle.
REQ-007 gnt  output  4  one-hot grant, registered.
REQ-008 sel  output  2  index of granted requester, registered; drives the 4:1 data mux.
REQ-009 mem_valid  output  1  transaction in progress, registered.
REQ-010 mem_wdata  output  32  wdata of granted requester; 0 when not BUSY.
REQ-011 done  output  4  one-cycle completion pulse to owner, registered.
REQ-012 timeout  output  1  one-cycle pulse on forced release, registered.

Function
REQ-013 The FSM SHALL have two states: IDLE and BUSY.
REQ-014 In IDLE with req != 0, the block SHALL pick the first asserted req bit searching upward from ptr (modulo 4), then on that edge set gnt one-hot, sel to the index, mem_valid=1, and enter BUSY.
REQ-015 Grant latency SHALL be one cycle: req is sampled at edge k and gnt/mem_valid are visible after edge k.
REQ-016 In IDLE with req == 0, the block SHALL hold all outputs at 0 and ptr unchanged.
REQ-017 In BUSY, mem_wdata SHALL equal wdata[sel] combinationally; wdata changes propagate in the same cycle.
REQ-018 In BUSY with mem_ready=1, the block SHALL, at that edge, clear gnt and mem_valid, pulse done[sel] for one cycle, set ptr=(sel+1) mod 4, and return to IDLE.
REQ-019 The block SHALL NOT grant in the cycle a transaction ends; the minimum gap between grants is one IDLE cycle.
REQ-020 The 8-bit wait counter SHALL clear on grant and increment each BUSY cycle without mem_ready.
REQ-021 When the counter equals TIMEOUT-1 and mem_ready=0, the block SHALL, at that edge, release as in REQ-018 but pulse timeout instead of done.
REQ-022 mem_ready and timeout in the same cycle SHALL resolve as normal completion: done pulses and timeout does not.
REQ-023 Deassertion of the owner's req while BUSY SHALL be ignored; the transaction continues to ready or timeout.
REQ-024 mem_ready in IDLE SHALL be ignored.
REQ-025 gnt SHALL never have more than one bit set, and gnt != 0 iff mem_valid=1.

Reset
REQ-026 With rst=1 at an edge, the block SHALL force state=IDLE, ptr=0, counter=0, and gnt, sel, mem_valid, done, timeout all 0, including mid-transaction, without pulsing done or timeout.
REQ-027 The first grant after reset SHALL favour requester 0.

Structure
REQ-028 The shared package SHALL hold the state enum (IDLE, BUSY), the requester count (4), the data width (32) and the default TIMEOUT constant.
REQ-029 The data path SHALL be one sub-module, wdata_mux4, a 32-bit 4:1 mux selected by sel; mem_wdata is gated to 0 outside BUSY.

Verification
REQ-030 Reset then req=4'b1010 -> gnt=4'b0010, sel=1 one cycle later; mem_ready after 3 cycles -> done=4'b0010 for one pulse, ptr=2.
REQ-031 req=4'b1111 held, mem_ready=1 one cycle after each grant -> grant order 0,1,2,3,0, with one IDLE cycle between grants.
REQ-032 Grant to 2 with wdata2=32'hDEADBEEF, then wdata2 changed to 32'h12345678 mid-BUSY -> mem_wdata follows in the same cycle; after release mem_wdata=0.
REQ-033 TIMEOUT=4, mem_ready held 0 -> timeout pulses at the 4th BUSY edge, gnt clears, no done pulse, next grant skips the timed-out requester.
REQ-034 mem_ready=1 in the cycle the count reaches TIMEOUT-1 -> done pulses and timeout stays 0.
REQ-035 rst asserted on the 2nd BUSY cycle -> all outputs 0 at the next edge; after rst deasserts with req=4'b1000 -> grant to 3 (search starts from 0).

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the round-robin memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic {IDLE, BUSY} state_t;

    localparam int unsigned NREQ            = 4;
    localparam int unsigned DW              = 32;
    localparam int unsigned TIMEOUT_DEFAULT = 15;

    // First asserted request at or above ptr, wrapping modulo NREQ.
    function automatic logic [1:0] pick_next(input logic [NREQ-1:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        pick_next = ptr;
        for (int unsigned k = NREQ; k >= 1; k--) begin
            idx = ptr + 2'(k - 1);
            if (req[idx]) pick_next = idx;
        end
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester/memory-side bundle of the arbiter; master drives requests, slave is the arbiter.
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    logic [NREQ-1:0] req;
    logic [DW-1:0]   wdata0;
    logic [DW-1:0]   wdata1;
    logic [DW-1:0]   wdata2;
    logic [DW-1:0]   wdata3;
    logic            mem_ready;
    logic [NREQ-1:0] gnt;
    logic [1:0]      sel;
    logic            mem_valid;
    logic [DW-1:0]   mem_wdata;
    logic [NREQ-1:0] done;
    logic            timeout;

    modport master (
        output req, wdata0, wdata1, wdata2, wdata3, mem_ready,
        input  gnt, sel, mem_valid, mem_wdata, done, timeout
    );

    modport slave (
        input  req, wdata0, wdata1, wdata2, wdata3, mem_ready,
        output gnt, sel, mem_valid, mem_wdata, done, timeout
    );
endinterface

// File: rtl/mem_port_arbiter_wdata_mux4.sv
// 32-bit 4:1 write-data mux; output forced to zero when not enabled.
module wdata_mux4
    import mem_port_arbiter_pkg::*;
(
    input  logic [DW-1:0] in0,
    input  logic [DW-1:0] in1,
    input  logic [DW-1:0] in2,
    input  logic [DW-1:0] in3,
    input  logic [1:0]    sel,
    input  logic          en,
    output logic [DW-1:0] out
);
    always_comb begin
        out = '0;
        if (en) begin
            case (sel)
                2'd0:    out = in0;
                2'd1:    out = in1;
                2'd2:    out = in2;
                default: out = in3;
            endcase
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for one shared memory port with a per-transaction wait timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    state_t          state, state_n;
    logic [1:0]      ptr, ptr_n;
    logic [7:0]      cnt, cnt_n;
    logic [NREQ-1:0] gnt_q, gnt_n;
    logic [1:0]      sel_q, sel_n;
    logic            valid_q, valid_n;
    logic [NREQ-1:0] done_q, done_n;
    logic            to_q, to_n;
    logic [1:0]      idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            cnt     <= '0;
            gnt_q   <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= '0;
            to_q    <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            cnt     <= cnt_n;
            gnt_q   <= gnt_n;
            sel_q   <= sel_n;
            valid_q <= valid_n;
            done_q  <= done_n;
            to_q    <= to_n;
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = cnt;
        gnt_n   = gnt_q;
        sel_n   = sel_q;
        valid_n = valid_q;
        done_n  = '0;
        to_n    = 1'b0;
        idx     = pick_next(bus.req, ptr);
        case (state)
            IDLE: begin
                gnt_n   = '0;
                sel_n   = '0;
                valid_n = 1'b0;
                if (bus.req != '0) begin
                    gnt_n[idx] = 1'b1;
                    sel_n      = idx;
                    valid_n    = 1'b1;
                    cnt_n      = '0;
                    state_n    = BUSY;
                end
            end
            BUSY: begin
                // Completion wins over a simultaneous timeout.
                if (bus.mem_ready || cnt == 8'(TIMEOUT - 1)) begin
                    if (bus.mem_ready) done_n[sel_q] = 1'b1;
                    else               to_n          = 1'b1;
                    gnt_n   = '0;
                    sel_n   = '0;
                    valid_n = 1'b0;
                    ptr_n   = sel_q + 2'd1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    wdata_mux4 u_mux (
        .in0 (bus.wdata0),
        .in1 (bus.wdata1),
        .in2 (bus.wdata2),
        .in3 (bus.wdata3),
        .sel (sel_q),
        .en  (state == BUSY),
        .out (bus.mem_wdata)
    );

    assign bus.gnt       = gnt_q;
    assign bus.sel       = sel_q;
    assign bus.mem_valid = valid_q;
    assign bus.done      = done_q;
    assign bus.timeout   = to_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner sequences, random vs model.
module tb_mem_port_arbiter;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: who owns the port, where the search resumes, stalled cycles so far.
    bit         m_busy;
    int         m_owner;
    int         m_ptr;
    int         m_wait;
    logic [3:0] m_done;
    logic       m_to;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit found;
        m_done = '0;
        m_to   = 1'b0;
        if (rst) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_wait = 0;
        end else if (!m_busy) begin
            found = 0;
            for (int k = 0; k < 4; k++) begin
                if (!found && bus.req[(m_ptr + k) % 4]) begin
                    found   = 1;
                    m_owner = (m_ptr + k) % 4;
                end
            end
            if (found) begin
                m_busy = 1;
                m_wait = 0;
            end
        end else if (bus.mem_ready) begin
            m_done = 4'b0001 << m_owner;
            m_busy = 0;
            m_ptr  = (m_owner + 1) % 4;
        end else if (m_wait + 1 == TO) begin
            m_to   = 1'b1;
            m_busy = 0;
            m_ptr  = (m_owner + 1) % 4;
        end else begin
            m_wait++;
        end
    endtask

    function automatic logic [31:0] model_wdata();
        if (!m_busy) return 32'h0;
        case (m_owner)
            0:       return bus.wdata0;
            1:       return bus.wdata1;
            2:       return bus.wdata2;
            default: return bus.wdata3;
        endcase
    endfunction

    task automatic model_check();
        chk("m_gnt",   32'(bus.gnt),       m_busy ? 32'(4'b0001 << m_owner) : 32'h0);
        chk("m_sel",   32'(bus.sel),       m_busy ? 32'(m_owner) : 32'h0);
        chk("m_valid", 32'(bus.mem_valid), 32'(m_busy));
        chk("m_done",  32'(bus.done),      32'(m_done));
        chk("m_to",    32'(bus.timeout),   32'(m_to));
        chk("m_wdata", bus.mem_wdata,      model_wdata());
        chk("onehot",  32'(($countones(bus.gnt) <= 1) && ((bus.gnt != 0) == bus.mem_valid)), 32'h1);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        model_check();
    endtask

    task automatic drive(input logic r, input logic [3:0] q, input logic rdy);
        rst = r; bus.req = q; bus.mem_ready = rdy;
    endtask

    task automatic do_reset();
        drive(1'b1, 4'b0000, 1'b0);
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       rdy;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       val;
        logic [3:0] done;
        logic       to;
    } vec_t;

    vec_t vecs [13];

    initial begin
        // reset, grant 1, ready after 3 cycles, then round robin from ptr=2
        vecs[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0};
        vecs[1]  = '{1'b0, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 4'b0000, 1'b0};
        vecs[2]  = '{1'b0, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 4'b0000, 1'b0};
        vecs[3]  = '{1'b0, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 4'b0000, 1'b0};
        vecs[4]  = '{1'b0, 4'b1010, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0010, 1'b0};
        vecs[5]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0};
        vecs[6]  = '{1'b0, 4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 4'b0000, 1'b0};
        vecs[7]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0100, 1'b0};
        vecs[8]  = '{1'b0, 4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 4'b0000, 1'b0};
        vecs[9]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b1000, 1'b0};
        vecs[10] = '{1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 4'b0000, 1'b0};
        vecs[11] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0001, 1'b0};
        vecs[12] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0};

        bus.wdata0 = 32'hA0A0_0000;
        bus.wdata1 = 32'hA1A1_1111;
        bus.wdata2 = 32'hA2A2_2222;
        bus.wdata3 = 32'hA3A3_3333;
        drive(1'b1, 4'b0000, 1'b0);
        #2;

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].rst, vecs[i].req, vecs[i].rdy);
            tick();
            chk($sformatf("v%0d_gnt", i),   32'(bus.gnt),       32'(vecs[i].gnt));
            chk($sformatf("v%0d_sel", i),   32'(bus.sel),       32'(vecs[i].sel));
            chk($sformatf("v%0d_valid", i), 32'(bus.mem_valid), 32'(vecs[i].val));
            chk($sformatf("v%0d_done", i),  32'(bus.done),      32'(vecs[i].done));
            chk($sformatf("v%0d_to", i),    32'(bus.timeout),   32'(vecs[i].to));
        end

        // all requesting, ready held high: 0,1,2,3,0 with an idle cycle between grants
        do_reset();
        drive(1'b0, 4'b1111, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr_gnt", 32'(bus.gnt), 32'(4'b0001 << (i % 4)));
            tick();
            chk("rr_gap", 32'(bus.gnt), 32'h0);
        end

        // write data follows wdata2 combinationally while busy, zero afterwards
        do_reset();
        bus.wdata2 = 32'hDEADBEEF;
        drive(1'b0, 4'b0100, 1'b0);
        tick();
        chk("wd_first", bus.mem_wdata, 32'hDEADBEEF);
        bus.wdata2 = 32'h12345678;
        #1;
        chk("wd_follow", bus.mem_wdata, 32'h12345678);
        bus.mem_ready = 1'b1;
        tick();
        chk("wd_zero", bus.mem_wdata, 32'h0);

        // timeout at the 4th stalled edge, then next grant skips requester 1
        do_reset();
        drive(1'b0, 4'b0010, 1'b0);
        tick();
        chk("to_gnt", 32'(bus.gnt), 32'h2);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to_early", 32'(bus.timeout), 32'h0);
        end
        tick();
        chk("to_pulse", 32'(bus.timeout), 32'h1);
        chk("to_gclr",  32'(bus.gnt),     32'h0);
        chk("to_nodone", 32'(bus.done),   32'h0);
        bus.req = 4'b0110;
        tick();
        chk("to_skip", 32'(bus.gnt), 32'h4);
        tick();
        chk("to_once", 32'(bus.timeout), 32'h0);

        // ready on the would-be timeout edge completes normally
        do_reset();
        drive(1'b0, 4'b0001, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) tick();
        bus.mem_ready = 1'b1;
        tick();
        chk("tie_done", 32'(bus.done),    32'h1);
        chk("tie_to",   32'(bus.timeout), 32'h0);

        // reset on the 2nd busy cycle; afterwards search restarts from 0
        do_reset();
        drive(1'b0, 4'b0100, 1'b0);
        tick();
        tick();
        drive(1'b1, 4'b0100, 1'b1);
        tick();
        chk("rst_gnt",   32'(bus.gnt),       32'h0);
        chk("rst_valid", 32'(bus.mem_valid), 32'h0);
        chk("rst_done",  32'(bus.done),      32'h0);
        chk("rst_to",    32'(bus.timeout),   32'h0);
        drive(1'b0, 4'b1000, 1'b0);
        tick();
        chk("rst_regrant", 32'(bus.gnt), 32'h8);
        chk("rst_sel",     32'(bus.sel), 32'h3);

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst           = ($urandom_range(0, 79) == 0);
            bus.req       = 4'($urandom_range(0, 15));
            bus.mem_ready = ($urandom_range(0, 3) == 0);
            bus.wdata0    = $urandom;
            bus.wdata1    = $urandom;
            bus.wdata2    = $urandom;
            bus.wdata3    = $urandom;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
